// File: rtl/pipe_line.sv
// Five-stage MIPS-subset core (IF, ID, EX, MEM, WB) with EX-stage forwarding,
// a one-cycle load-use stall, and a two-bubble flush when a transfer resolves taken in EX.
module pipe_line (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instMemAddress,
    input  logic [31:0] instruction,
    output logic [31:0] dataMemAddress,
    output logic [31:0] dataMemWriteData,
    output logic        dataMemWrite,
    output logic        dataMemRead,
    input  logic [31:0] dataMemReadData
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
    typedef enum logic [2:0] {XFER_NONE, XFER_BEQ, XFER_BNE, XFER_J, XFER_JR} xfer_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc4_q, ifid_pc4_d;

    logic        idex_reg_write_q, idex_mem_read_q, idex_mem_write_q, idex_use_imm_q, idex_link_q;
    alu_op_e     idex_alu_op_q;
    xfer_e       idex_xfer_q;
    logic [4:0]  idex_rs_q, idex_rt_q, idex_dest_q;
    logic [31:0] idex_rs_val_q, idex_rt_val_q, idex_imm_q, idex_pc4_q;
    logic [25:0] idex_jaddr_q;

    logic        exmem_reg_write_q, exmem_mem_read_q, exmem_mem_write_q;
    logic [4:0]  exmem_dest_q;
    logic [31:0] exmem_result_q, exmem_store_q;

    logic        memwb_reg_write_q;
    logic [4:0]  memwb_dest_q;
    logic [31:0] memwb_result_q;

    logic [31:0] rf_q [32];

    // ID stage decode
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm, id_rs_val, id_rt_val;
    logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_use_imm, dec_link;
    alu_op_e     dec_alu_op;
    xfer_e       dec_xfer;
    logic [4:0]  dec_dest;

    assign id_op    = ifid_instr_q[31:26];
    assign id_rs    = ifid_instr_q[25:21];
    assign id_rt    = ifid_instr_q[20:16];
    assign id_rd    = ifid_instr_q[15:11];
    assign id_funct = ifid_instr_q[5:0];
    assign id_imm   = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};

    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_use_imm   = 1'b0;
        dec_link      = 1'b0;
        dec_alu_op    = ALU_ADD;
        dec_xfer      = XFER_NONE;
        dec_dest      = id_rt;
        case (id_op)
            6'h00: begin
                dec_dest = id_rd;
                case (id_funct)
                    6'h20: dec_reg_write = 1'b1;
                    6'h22: begin dec_reg_write = 1'b1; dec_alu_op = ALU_SUB; end
                    6'h24: begin dec_reg_write = 1'b1; dec_alu_op = ALU_AND; end
                    6'h25: begin dec_reg_write = 1'b1; dec_alu_op = ALU_OR;  end
                    6'h2A: begin dec_reg_write = 1'b1; dec_alu_op = ALU_SLT; end
                    6'h08: dec_xfer = XFER_JR;
                    default: ;
                endcase
            end
            6'h08: begin dec_reg_write = 1'b1; dec_use_imm = 1'b1; end
            6'h0A: begin dec_reg_write = 1'b1; dec_use_imm = 1'b1; dec_alu_op = ALU_SLT; end
            6'h23: begin dec_reg_write = 1'b1; dec_use_imm = 1'b1; dec_mem_read = 1'b1; end
            6'h2B: begin dec_use_imm = 1'b1; dec_mem_write = 1'b1; end
            6'h04: dec_xfer = XFER_BEQ;
            6'h05: dec_xfer = XFER_BNE;
            6'h02: dec_xfer = XFER_J;
            6'h03: begin
                dec_xfer      = XFER_J;
                dec_link      = 1'b1;
                dec_reg_write = 1'b1;
                dec_dest      = 5'd31;
            end
            default: ;
        endcase
    end

    // Register read with write-through from the instruction currently in WB
    always_comb begin
        id_rs_val = rf_q[id_rs];
        if (id_rs == 5'd0)
            id_rs_val = '0;
        else if (memwb_reg_write_q && memwb_dest_q == id_rs)
            id_rs_val = memwb_result_q;
        id_rt_val = rf_q[id_rt];
        if (id_rt == 5'd0)
            id_rt_val = '0;
        else if (memwb_reg_write_q && memwb_dest_q == id_rt)
            id_rt_val = memwb_result_q;
    end

    logic load_use;
    assign load_use = idex_mem_read_q && (idex_rt_q == id_rs || idex_rt_q == id_rt);

    // EX stage
    logic [31:0] fwd_a, fwd_b, alu_b, alu_res, ex_result, ex_target;
    logic        ex_taken;

    always_comb begin
        fwd_a = idex_rs_val_q;
        if (exmem_reg_write_q && exmem_dest_q != 5'd0 && exmem_dest_q == idex_rs_q)
            fwd_a = exmem_result_q;
        else if (memwb_reg_write_q && memwb_dest_q != 5'd0 && memwb_dest_q == idex_rs_q)
            fwd_a = memwb_result_q;
        fwd_b = idex_rt_val_q;
        if (exmem_reg_write_q && exmem_dest_q != 5'd0 && exmem_dest_q == idex_rt_q)
            fwd_b = exmem_result_q;
        else if (memwb_reg_write_q && memwb_dest_q != 5'd0 && memwb_dest_q == idex_rt_q)
            fwd_b = memwb_result_q;

        alu_b = idex_use_imm_q ? idex_imm_q : fwd_b;
        case (idex_alu_op_q)
            ALU_SUB: alu_res = fwd_a - alu_b;
            ALU_AND: alu_res = fwd_a & alu_b;
            ALU_OR:  alu_res = fwd_a | alu_b;
            ALU_SLT: alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            default: alu_res = fwd_a + alu_b;
        endcase
        ex_result = idex_link_q ? idex_pc4_q : alu_res;

        ex_taken  = 1'b0;
        ex_target = idex_pc4_q + {idex_imm_q[29:0], 2'b00};
        case (idex_xfer_q)
            XFER_BEQ: ex_taken = (fwd_a == fwd_b);
            XFER_BNE: ex_taken = (fwd_a != fwd_b);
            XFER_J: begin
                ex_taken  = 1'b1;
                ex_target = {idex_pc4_q[31:28], idex_jaddr_q, 2'b00};
            end
            XFER_JR: begin
                ex_taken  = 1'b1;
                ex_target = fwd_a;
            end
            default: ;
        endcase
    end

    // A taken transfer outranks the stall: the stalled instruction is flushed anyway
    always_comb begin
        pc_d         = pc_q + 32'd4;
        ifid_instr_d = instruction;
        ifid_pc4_d   = pc_q + 32'd4;
        if (ex_taken) begin
            pc_d         = ex_target;
            ifid_instr_d = '0;
            ifid_pc4_d   = '0;
        end else if (load_use) begin
            pc_d         = pc_q;
            ifid_instr_d = ifid_instr_q;
            ifid_pc4_d   = ifid_pc4_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q              <= '0;
            ifid_instr_q      <= '0;
            ifid_pc4_q        <= '0;
            idex_reg_write_q  <= 1'b0;
            idex_mem_read_q   <= 1'b0;
            idex_mem_write_q  <= 1'b0;
            idex_use_imm_q    <= 1'b0;
            idex_link_q       <= 1'b0;
            idex_alu_op_q     <= ALU_ADD;
            idex_xfer_q       <= XFER_NONE;
            idex_rs_q         <= '0;
            idex_rt_q         <= '0;
            idex_dest_q       <= '0;
            idex_rs_val_q     <= '0;
            idex_rt_val_q     <= '0;
            idex_imm_q        <= '0;
            idex_pc4_q        <= '0;
            idex_jaddr_q      <= '0;
            exmem_reg_write_q <= 1'b0;
            exmem_mem_read_q  <= 1'b0;
            exmem_mem_write_q <= 1'b0;
            exmem_dest_q      <= '0;
            exmem_result_q    <= '0;
            exmem_store_q     <= '0;
            memwb_reg_write_q <= 1'b0;
            memwb_dest_q      <= '0;
            memwb_result_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;

            idex_rs_q     <= id_rs;
            idex_rt_q     <= id_rt;
            idex_dest_q   <= dec_dest;
            idex_rs_val_q <= id_rs_val;
            idex_rt_val_q <= id_rt_val;
            idex_imm_q    <= id_imm;
            idex_pc4_q    <= ifid_pc4_q;
            idex_jaddr_q  <= ifid_instr_q[25:0];
            idex_alu_op_q <= dec_alu_op;
            idex_use_imm_q <= dec_use_imm;
            if (ex_taken || load_use) begin
                idex_reg_write_q <= 1'b0;
                idex_mem_read_q  <= 1'b0;
                idex_mem_write_q <= 1'b0;
                idex_link_q      <= 1'b0;
                idex_xfer_q      <= XFER_NONE;
            end else begin
                idex_reg_write_q <= dec_reg_write;
                idex_mem_read_q  <= dec_mem_read;
                idex_mem_write_q <= dec_mem_write;
                idex_link_q      <= dec_link;
                idex_xfer_q      <= dec_xfer;
            end

            exmem_reg_write_q <= idex_reg_write_q;
            exmem_mem_read_q  <= idex_mem_read_q;
            exmem_mem_write_q <= idex_mem_write_q;
            exmem_dest_q      <= idex_dest_q;
            exmem_result_q    <= ex_result;
            exmem_store_q     <= fwd_b;

            memwb_reg_write_q <= exmem_reg_write_q;
            memwb_dest_q      <= exmem_dest_q;
            memwb_result_q    <= exmem_mem_read_q ? dataMemReadData : exmem_result_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                rf_q[i] <= '0;
        end else if (memwb_reg_write_q && memwb_dest_q != 5'd0) begin
            rf_q[memwb_dest_q] <= memwb_result_q;
        end
    end

    assign instMemAddress   = pc_q;
    assign dataMemAddress   = exmem_result_q;
    assign dataMemWriteData = exmem_store_q;
    assign dataMemWrite     = exmem_mem_write_q;
    assign dataMemRead      = exmem_mem_read_q;
endmodule

// File: tb/tb_pipe_line.sv
// Bench for pipe_line: directed programs plus randomized ones, checked against an
// instruction-level reference that predicts every store and the cycle it appears in MEM.
module tb_pipe_line;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instMemAddress, instruction;
    logic [31:0] dataMemAddress, dataMemWriteData, dataMemReadData;
    logic        dataMemWrite, dataMemRead;

    logic [31:0] imem      [0:255];
    logic [31:0] dmem      [0:63];
    logic [31:0] dmem_init [0:63];

    int checks = 0;
    int errors = 0;

    logic [31:0] pcs[$];
    logic [31:0] st_addr[$], st_data[$];
    int          st_cyc[$];
    logic [31:0] m_addr[$], m_data[$];
    int          m_cyc[$];

    pipe_line dut (
        .clk              (clk),
        .rst              (rst),
        .instMemAddress   (instMemAddress),
        .instruction      (instruction),
        .dataMemAddress   (dataMemAddress),
        .dataMemWriteData (dataMemWriteData),
        .dataMemWrite     (dataMemWrite),
        .dataMemRead      (dataMemRead),
        .dataMemReadData  (dataMemReadData)
    );

    always #10 clk = ~clk;

    assign instruction     = imem[instMemAddress[9:2]];
    assign dataMemReadData = dmem[dataMemAddress[7:2]];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input int fn, input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_ins(input int op, input int word_addr);
        return {6'(op), 26'(word_addr)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = '0;
        for (int i = 0; i < 64; i++) dmem_init[i] = '0;
    endtask

    // Instruction-level reference: executes one instruction at a time and tracks the
    // MEM cycle of each instruction from the pipeline's cost rules.
    task automatic model_run();
        logic [31:0] r [0:31];
        logic [31:0] m [0:63];
        logic [31:0] pc, ins, a, b, imm, nxt, res, addr;
        logic [4:0]  dst, prev_rt;
        bit          taken, wr, prev_lw, prev_taken;
        int          e;
        m_addr.delete(); m_data.delete(); m_cyc.delete();
        for (int i = 0; i < 32; i++) r[i] = '0;
        for (int i = 0; i < 64; i++) m[i] = dmem_init[i];
        pc = '0; e = 3; prev_lw = 0; prev_taken = 0; prev_rt = '0;
        for (int step = 0; step < 4000; step++) begin
            ins = imem[pc[9:2]];
            if (step > 0)
                e += 1 + (prev_taken ? 2 : 0)
                       + ((prev_lw && (ins[25:21] == prev_rt || ins[20:16] == prev_rt)) ? 1 : 0);
            a = r[ins[25:21]];
            b = r[ins[20:16]];
            imm = {{16{ins[15]}}, ins[15:0]};
            nxt = pc + 4; taken = 0; wr = 0; dst = ins[20:16]; res = '0;
            addr = a + imm;
            case (ins[31:26])
                6'h00: begin
                    dst = ins[15:11];
                    case (ins[5:0])
                        6'h20: begin res = a + b; wr = 1; end
                        6'h22: begin res = a - b; wr = 1; end
                        6'h24: begin res = a & b; wr = 1; end
                        6'h25: begin res = a | b; wr = 1; end
                        6'h2A: begin res = ($signed(a) < $signed(b)) ? 1 : 0; wr = 1; end
                        6'h08: begin taken = 1; nxt = a; end
                        default: ;
                    endcase
                end
                6'h08: begin res = a + imm; wr = 1; end
                6'h0A: begin res = ($signed(a) < $signed(imm)) ? 1 : 0; wr = 1; end
                6'h23: begin res = m[addr[7:2]]; wr = 1; end
                6'h2B: begin
                    m[addr[7:2]] = b;
                    m_addr.push_back(addr); m_data.push_back(b); m_cyc.push_back(e);
                end
                6'h04: if (a == b) begin taken = 1; nxt = pc + 4 + (imm << 2); end
                6'h05: if (a != b) begin taken = 1; nxt = pc + 4 + (imm << 2); end
                6'h02: begin taken = 1; nxt = {pc[31:28], ins[25:0], 2'b00}; end
                6'h03: begin
                    taken = 1; nxt = {pc[31:28], ins[25:0], 2'b00};
                    wr = 1; dst = 5'd31; res = pc + 4;
                end
                default: ;
            endcase
            if (wr && dst != 5'd0) r[dst] = res;
            prev_lw = (ins[31:26] == 6'h23);
            prev_rt = ins[20:16];
            prev_taken = taken;
            if (taken && nxt == pc) break;
            pc = nxt;
        end
    endtask

    task automatic run_dut(input int ncyc);
        pcs.delete(); st_addr.delete(); st_data.delete(); st_cyc.delete();
        for (int i = 0; i < 64; i++) dmem[i] = dmem_init[i];
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            pcs.push_back(instMemAddress);
            if (dataMemWrite === 1'b1) begin
                st_addr.push_back(dataMemAddress);
                st_data.push_back(dataMemWriteData);
                st_cyc.push_back(c);
                dmem[dataMemAddress[7:2]] = dataMemWriteData;
            end
        end
    endtask

    task automatic compare_stores(input string name);
        model_run();
        check_val($sformatf("%s nstores", name), st_addr.size(), m_addr.size());
        for (int k = 0; k < m_addr.size(); k++) begin
            if (k < st_addr.size()) begin
                check_val($sformatf("%s st%0d addr", name, k), st_addr[k], m_addr[k]);
                check_val($sformatf("%s st%0d data", name, k), st_data[k], m_data[k]);
                check_val($sformatf("%s st%0d cycle", name, k), st_cyc[k], m_cyc[k]);
            end
        end
    endtask

    function automatic logic [31:0] first_data();
        return (st_data.size() > 0) ? st_data[0] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] first_addr();
        return (st_addr.size() > 0) ? st_addr[0] : 32'hDEAD_BEEF;
    endfunction

    task automatic gen_random(input int n);
        int fns [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        int regs[8] = '{1, 2, 3, 4, 5, 6, 7, 31};
        clear_mem();
        for (int i = 0; i < 64; i++) dmem_init[i] = $urandom;
        for (int i = 0; i < n; i++) begin
            int k   = $urandom_range(0, 11);
            int rs  = $urandom_range(0, 7);
            int rt  = $urandom_range(0, 7);
            int rd  = $urandom_range(0, 7);
            int lim = (n - 1 - i) < 3 ? (n - 1 - i) : 3;
            int off = $urandom_range(0, lim);
            case (k)
                0, 1, 2, 3, 4: imem[i] = r_ins(fns[k], rs, rt, rd);
                5:  imem[i] = i_ins(8'h08, rs, rt, $urandom_range(0, 65535));
                6:  imem[i] = i_ins(8'h0A, rs, rt, $urandom_range(0, 65535));
                7:  imem[i] = i_ins(8'h23, 0, rt, 4 * $urandom_range(0, 31));
                8:  imem[i] = i_ins(8'h2B, 0, rt, 4 * $urandom_range(0, 31));
                9:  imem[i] = i_ins($urandom_range(0, 1) ? 8'h04 : 8'h05, rs, rt, off);
                10: imem[i] = $urandom_range(0, 1) ? 32'h0 : {6'h3F, 26'($urandom)};
                default: imem[i] = j_ins($urandom_range(0, 1) ? 8'h02 : 8'h03, i + 1 + off);
            endcase
        end
        for (int j = 0; j < 8; j++)
            imem[n + j] = i_ins(8'h2B, 0, regs[j], 128 + 4 * j);
        imem[n + 8] = i_ins(8'h04, 0, 0, -1);
    endtask

    task automatic load_maxfind();
        clear_mem();
        imem[0]  = i_ins(8'h08, 0, 1, 0);
        imem[1]  = i_ins(8'h08, 0, 2, 80);
        imem[2]  = i_ins(8'h23, 0, 3, 0);
        imem[3]  = i_ins(8'h08, 0, 4, 0);
        imem[4]  = i_ins(8'h08, 0, 5, 0);
        imem[5]  = i_ins(8'h08, 1, 1, 4);
        imem[6]  = i_ins(8'h08, 5, 5, 1);
        imem[7]  = i_ins(8'h04, 1, 2, 7);
        imem[8]  = i_ins(8'h23, 1, 6, 0);
        imem[9]  = r_ins(8'h2A, 3, 6, 7);
        imem[10] = i_ins(8'h05, 7, 0, 1);
        imem[11] = j_ins(8'h02, 5);
        imem[12] = r_ins(8'h20, 6, 0, 3);
        imem[13] = r_ins(8'h20, 5, 0, 4);
        imem[14] = j_ins(8'h02, 5);
        imem[15] = i_ins(8'h2B, 0, 3, 128);
        imem[16] = i_ins(8'h2B, 0, 4, 132);
        imem[17] = i_ins(8'h04, 0, 0, -1);
    endtask

    initial begin
        int holds;
        int best;
        rst = 1'b0;

        // Forwarding chain, also used for the reset checks
        clear_mem();
        imem[0] = i_ins(8'h08, 0, 1, 5);
        imem[1] = r_ins(8'h20, 1, 1, 2);
        imem[2] = r_ins(8'h22, 2, 1, 3);
        imem[3] = i_ins(8'h2B, 0, 3, 0);
        imem[4] = i_ins(8'h04, 0, 0, -1);
        #50;
        @(negedge clk);
        check_val("reset pc", instMemAddress, 0);
        check_val("reset daddr", dataMemAddress, 0);
        check_val("reset wdata", dataMemWriteData, 0);
        check_val("reset dwrite", dataMemWrite, 0);
        check_val("reset dread", dataMemRead, 0);
        run_dut(14);
        for (int c = 0; c < 5; c++)
            check_val($sformatf("fwd pc c%0d", c), pcs[c], 4 * c);
        check_val("fwd sw addr", first_addr(), 0);
        check_val("fwd sw data", first_data(), 5);
        compare_stores("fwd");

        // Reset asserted while the sw is in MEM
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (7) @(negedge clk);
        check_val("mid sw visible", dataMemWrite, 1);
        #2 rst = 1'b0;
        #1;
        check_val("mid reset pc", instMemAddress, 0);
        check_val("mid reset dwrite", dataMemWrite, 0);
        check_val("mid reset daddr", dataMemAddress, 0);
        check_val("mid reset wdata", dataMemWriteData, 0);

        // Load-use
        clear_mem();
        dmem_init[1] = 32'd7;
        imem[0] = i_ins(8'h23, 0, 4, 4);
        imem[1] = i_ins(8'h08, 4, 5, 1);
        imem[2] = i_ins(8'h2B, 0, 5, 8);
        imem[3] = i_ins(8'h04, 0, 0, -1);
        run_dut(16);
        holds = 0;
        for (int c = 1; c < 6; c++)
            if (pcs[c] == pcs[c - 1]) holds++;
        check_val("lu holds", holds, 1);
        check_val("lu pc c3", pcs[3], 8);
        check_val("lu sw addr", first_addr(), 8);
        check_val("lu sw data", first_data(), 8);
        compare_stores("lu");

        // Taken beq over two addi
        clear_mem();
        imem[0] = i_ins(8'h04, 0, 0, 2);
        imem[1] = i_ins(8'h08, 0, 6, 1);
        imem[2] = i_ins(8'h08, 0, 6, 1);
        imem[3] = i_ins(8'h2B, 0, 6, 20);
        imem[4] = i_ins(8'h04, 0, 0, -1);
        run_dut(16);
        check_val("beq pc c3", pcs[3], 12);
        check_val("beq r6 untouched", first_data(), 0);
        compare_stores("beq");

        // jal / jr
        clear_mem();
        imem[0]  = j_ins(8'h03, 16);
        imem[1]  = i_ins(8'h2B, 0, 31, 16);
        imem[2]  = i_ins(8'h04, 0, 0, -1);
        imem[16] = r_ins(8'h08, 31, 0, 0);
        run_dut(20);
        check_val("jal pc c3", pcs[3], 32'h40);
        check_val("jr pc c6", pcs[6], 4);
        check_val("jal r31", first_data(), 4);
        compare_stores("jal");

        // Max-finding over random arrays
        for (int t = 0; t < 3; t++) begin
            load_maxfind();
            for (int i = 0; i < 20; i++)
                dmem_init[i] = (t == 2) ? 32'($signed($urandom_range(0, 6)) - 3) : $urandom;
            best = 0;
            for (int i = 1; i < 20; i++)
                if ($signed(dmem_init[i]) > $signed(dmem_init[best])) best = i;
            run_dut(700);
            check_val($sformatf("max%0d value", t), dmem[32], dmem_init[best]);
            check_val($sformatf("max%0d index", t), dmem[33], best);
            compare_stores($sformatf("max%0d", t));
        end

        // Random programs
        for (int t = 0; t < 6; t++) begin
            gen_random(40);
            run_dut(300);
            compare_stores($sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
